// File: rtl/fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encodings, default widths, reset PC and NOP word.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_REQ  = 2'd0;
    localparam fetch_state_t S_WAIT = 2'd1;
    localparam fetch_state_t S_HOLD = 2'd2;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC helper: sequential PC+4, JALR-style masked redirect target and
// the bit-1 misalignment flag of the requested target.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_br_target,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign
);

    assign o_pc_plus4 = i_pc + XLEN'(4);
    assign o_target   = i_br_target & ~XLEN'(1);
    assign o_misalign = i_br_target[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps at most one imem request in flight and
// squashes wrong-path fetches on redirect. Define PC_FETCH_MISALIGN_TRAP_EN to trap bit-1 targets.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BrValid,
    input  logic            NextPCSrc,
    input  logic [XLEN-1:0] BrTarget,
    output logic            IMemReqValid,
    input  logic            IMemReqReady,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemRespValid,
    input  logic [XLEN-1:0] IMemRespData,
    output logic            InstValid,
    input  logic            InstReady,
    output logic [XLEN-1:0] Inst,
    output logic [XLEN-1:0] InstPC,
    output logic [XLEN-1:0] InstPCPlus4,
    output logic            Flush
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    ,
    output logic            MisalignErr,
    output logic [XLEN-1:0] BadAddr
`endif
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_kill;
    logic            r_inst_valid;

    logic            w_redirect;
    logic            w_misalign;
    logic            w_trap;
    logic            w_frozen;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;

    pc_next_calc #(
        .XLEN(XLEN)
    ) u_pc_next_calc (
        .i_pc       (r_pc),
        .i_br_target(BrTarget),
        .o_pc_plus4 (w_pc_plus4),
        .o_target   (w_target),
        .o_misalign (w_misalign)
    );

    assign w_redirect = BrValid & NextPCSrc;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic            r_misalign_err;
    logic [XLEN-1:0] r_bad_addr;

    assign w_frozen    = r_misalign_err;
    assign w_trap      = w_redirect & w_misalign & ~r_misalign_err;
    assign MisalignErr = r_misalign_err;
    assign BadAddr     = r_bad_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign_err <= 1'b0;
            r_bad_addr     <= '0;
        end else if (w_trap) begin
            r_misalign_err <= 1'b1;
            r_bad_addr     <= w_target;
        end
    end
`else
    logic w_unused_misalign;

    assign w_frozen          = 1'b0;
    assign w_trap            = 1'b0;
    assign w_unused_misalign = w_misalign;
`endif

    assign IMemReqValid = rst_n & (r_state == S_REQ) & ~w_frozen;
    assign IMemAddr     = r_pc;
    assign InstValid    = r_inst_valid;
    assign Inst         = r_inst;
    assign InstPC       = r_inst_pc;
    assign InstPCPlus4  = r_inst_pc + XLEN'(4);
    assign Flush        = w_redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else if (w_trap) begin
            // Park in S_REQ with requests masked; any in-flight response is ignored there.
            r_state      <= S_REQ;
            r_kill       <= 1'b0;
            r_inst_valid <= 1'b0;
        end else if (!w_frozen) begin
            case (r_state)
                S_REQ: begin
                    if (IMemReqReady) begin
                        r_state <= S_WAIT;
                    end
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (IMemReqReady) begin
                            r_kill <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                        if (IMemRespValid) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (IMemRespValid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst       <= IMemRespData;
                            r_inst_pc    <= r_pc;
                            r_pc         <= w_pc_plus4;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Redirect wins over a same-cycle InstReady.
                    if (w_redirect) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_target;
                        r_state      <= S_REQ;
                    end else if (InstReady) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: transaction-level model (pending request / held instruction) checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        BrValid = 1'b0;
    logic        NextPCSrc = 1'b0;
    logic [31:0] BrTarget = 32'h0;
    logic        IMemReqValid;
    logic        IMemReqReady = 1'b0;
    logic [31:0] IMemAddr;
    logic        IMemRespValid = 1'b0;
    logic [31:0] IMemRespData = 32'h0;
    logic        InstValid;
    logic        InstReady = 1'b0;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic [31:0] InstPCPlus4;
    logic        Flush;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic        MisalignErr;
    logic [31:0] BadAddr;
`endif

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .XLEN    (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .BrValid      (BrValid),
        .NextPCSrc    (NextPCSrc),
        .BrTarget     (BrTarget),
        .IMemReqValid (IMemReqValid),
        .IMemReqReady (IMemReqReady),
        .IMemAddr     (IMemAddr),
        .IMemRespValid(IMemRespValid),
        .IMemRespData (IMemRespData),
        .InstValid    (InstValid),
        .InstReady    (InstReady),
        .Inst         (Inst),
        .InstPC       (InstPC),
        .InstPCPlus4  (InstPCPlus4),
        .Flush        (Flush)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        ,
        .MisalignErr  (MisalignErr),
        .BadAddr      (BadAddr)
`endif
    );

    int n_checks = 0;
    int n_pass = 0;

    // Memory: one response, mem_lat cycles after acceptance.
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'h0;

    // Model: one possibly-killed pending request, one held instruction.
    bit          m_pend = 0;
    bit          m_pend_kill = 0;
    bit          m_held = 0;
    bit          m_frozen = 0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_pend_addr = 32'h0;
    logic [31:0] m_held_data = 32'h0;
    logic [31:0] m_held_pc = 32'h0;

    logic [31:0] issued[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_plus4[$];
    bit          seen_104 = 0;
    logic        l_flush = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle(input logic br, input logic src, input logic [31:0] tgt,
                         input logic rdy, input logic mrdy);
        logic        redir;
        logic        resp;
        logic        exp_req;
        logic        acc;
        logic [31:0] etgt;
        BrValid       = br;
        NextPCSrc     = src;
        BrTarget      = tgt;
        InstReady     = rdy;
        IMemReqReady  = mrdy;
        resp          = mem_busy && (mem_cnt == 0);
        IMemRespValid = resp;
        IMemRespData  = resp ? mem_data(mem_addr) : 32'h0;
        #1;
        redir = br & src;
        etgt  = {tgt[31:1], 1'b0};
        l_flush = Flush;
        if (!rst_n) begin
            chk("req_in_reset", 32'(IMemReqValid), 32'h0);
        end else begin
            exp_req = !m_pend && !m_held && !m_frozen;
            chk("req_valid", 32'(IMemReqValid), 32'(exp_req));
            if (exp_req) chk("req_addr", IMemAddr, m_pc);
            chk("inst_valid", 32'(InstValid), 32'(m_held));
            if (m_held) begin
                chk("inst", Inst, m_held_data);
                chk("inst_pc", InstPC, m_held_pc);
                chk("inst_pc4", InstPCPlus4, m_held_pc + 32'd4);
            end
        end
        chk("flush", 32'(Flush), 32'(redir));

        acc = IMemReqValid && mrdy;
        chk("one_outstanding", 32'(acc && mem_busy && !resp), 32'h0);
        if (acc) issued.push_back(IMemAddr);
        if (rst_n && InstValid && rdy && !Flush) begin
            acc_pc.push_back(InstPC);
            acc_plus4.push_back(InstPCPlus4);
        end
        if (InstValid && InstPC == 32'h104) seen_104 = 1;

        if (resp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1;
            mem_addr = IMemAddr;
            mem_cnt  = mem_lat - 1;
        end

        if (!rst_n) begin
            m_pc = RST_PC; m_pend = 0; m_pend_kill = 0; m_held = 0; m_frozen = 0;
        end else if (m_frozen) begin
            m_pend = 0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        end else if (redir && etgt[1]) begin
            m_frozen = 1; m_pend = 0; m_held = 0;
`endif
        end else if (m_held) begin
            if (redir) begin
                m_held = 0;
                m_pc   = etgt;
            end else if (rdy) begin
                m_held = 0;
            end
        end else if (m_pend) begin
            if (resp) begin
                if (!m_pend_kill && !redir) begin
                    m_held      = 1;
                    m_held_data = mem_data(m_pend_addr);
                    m_held_pc   = m_pend_addr;
                    m_pc        = m_pend_addr + 32'd4;
                end
                m_pend = 0;
            end else if (redir) begin
                m_pend_kill = 1;
            end
            if (redir) m_pc = etgt;
        end else begin
            if (mrdy) begin
                m_pend      = 1;
                m_pend_addr = m_pc;
                m_pend_kill = redir;
            end
            if (redir) m_pc = etgt;
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) cycle(1'b0, 1'b0, 32'h0, rdy, 1'b1);
    endtask

    task automatic clear_logs();
        issued.delete();
        acc_pc.delete();
        acc_plus4.delete();
        seen_104 = 0;
    endtask

    task automatic do_reset(input bit keep_mem);
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        if (!keep_mem) mem_busy = 0;
        clear_logs();
    endtask

    task automatic advance_until_pend(input logic [31:0] a, input logic rdy);
        int k = 0;
        while (!(m_pend && m_pend_addr == a) && k < 40) begin
            cycle(1'b0, 1'b0, 32'h0, rdy, 1'b1);
            k++;
        end
        chk("reach_pending", 32'(k < 40), 32'h1);
    endtask

    task automatic advance_until_held();
        int k = 0;
        while (!m_held && k < 40) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            k++;
        end
        chk("reach_held", 32'(k < 40), 32'h1);
    endtask

    initial begin
        @(negedge clk);

        // Straight-line fetch from RESET_PC.
        do_reset(0);
        mem_lat = 1;
        chk("reset_inst_valid", 32'(InstValid), 32'h0);
        chk("reset_req_addr", IMemAddr, 32'h100);
        idle(9, 1'b1);
        chk("t1_addr0", issued[0], 32'h100);
        chk("t1_addr1", issued[1], 32'h104);
        chk("t1_addr2", issued[2], 32'h108);
        chk("t1_pc0", acc_pc[0], 32'h100);
        chk("t1_pc2", acc_pc[2], 32'h108);
        chk("t1_plus4", acc_plus4[0], 32'h104);

        // Redirect while 0x104 is outstanding.
        do_reset(0);
        mem_lat = 3;
        advance_until_pend(32'h104, 1'b1);
        cycle(1'b1, 1'b1, 32'h2001, 1'b1, 1'b1);
        idle(12, 1'b1);
        chk("t2_addr1", issued[1], 32'h104);
        chk("t2_addr2", issued[2], 32'h2000);
        chk("t2_no_104", 32'(seen_104), 32'h0);
        chk("t2_pc1", acc_pc[1], 32'h2000);

        // Redirect in hold together with InstReady.
        do_reset(0);
        mem_lat = 1;
        advance_until_held();
        cycle(1'b1, 1'b1, 32'h3000, 1'b1, 1'b1);
        chk("t3_flush", 32'(l_flush), 32'h1);
        chk("t3_drop", 32'(InstValid), 32'h0);
        idle(6, 1'b1);
        chk("t3_addr1", issued[1], 32'h3000);
        chk("t3_first_acc", acc_pc[0], 32'h3000);

        // Decode stall for 5 cycles.
        do_reset(0);
        advance_until_held();
        repeat (5) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            chk("t4_inst", Inst, mem_data(32'h100));
            chk("t4_pc", InstPC, 32'h100);
            chk("t4_noreq", 32'(IMemReqValid), 32'h0);
        end
        idle(4, 1'b1);
        chk("t4_next_addr", issued[1], 32'h104);

        // PC wrap.
        do_reset(0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        idle(8, 1'b1);
        chk("t5_addr0", issued[0], 32'hFFFF_FFFC);
        chk("t5_addr1", issued[1], 32'h0);
        chk("t5_pc0", acc_pc[0], 32'hFFFF_FFFC);
        chk("t5_plus4", acc_plus4[0], 32'h0);

        // Reset with a request in flight; the stale response lands in S_REQ.
        do_reset(0);
        mem_lat = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        clear_logs();
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(8, 1'b1);
        chk("t6_addr0", issued[0], 32'h100);
        chk("t6_pc0", acc_pc[0], 32'h100);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
        do_reset(0);
        mem_lat = 1;
        cycle(1'b1, 1'b1, 32'h1002, 1'b1, 1'b0);
        chk("t7_err", 32'(MisalignErr), 32'h1);
        chk("t7_bad", BadAddr, 32'h1002);
        idle(5, 1'b1);
        chk("t7_no_req", 32'(issued.size()), 32'h0);
        do_reset(0);
        chk("t7_err_clr", 32'(MisalignErr), 32'h0);
        idle(3, 1'b1);
        chk("t7_resume", issued[0], 32'h100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
